// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings and default busy latencies.
package mdu_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10
  } md_op_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: multiply, divide and (with MDU_MADD_EN) multiply-accumulate.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_MADD_EN
  input  logic [31:0] hi,
  input  logic [31:0] lo,
`endif
  output logic        is_mul,
  output logic        is_div,
  output logic        wr_en,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s_s;
  logic [63:0] prod_u_s;
  logic        div_sgn_s;
  logic [31:0] dvd_s;
  logic [31:0] dvs_s;
  logic [31:0] qm_s;
  logic [31:0] rm_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  // The low 64 bits of a 64x64 product of sign-extended operands is the signed product.
  assign prod_s_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u_s = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes; a zero divisor is swapped for 1 so no X leaks out.
  assign div_sgn_s = (op == MD_DIV);
  assign dvd_s = (div_sgn_s && a[31]) ? (32'd0 - a) : a;
  assign dvs_s = (b == 32'd0) ? 32'd1 :
                 ((div_sgn_s && b[31]) ? (32'd0 - b) : b);
  assign qm_s  = dvd_s / dvs_s;
  assign rm_s  = dvd_s % dvs_s;
  assign quo_s = (div_sgn_s && (a[31] ^ b[31])) ? (32'd0 - qm_s) : qm_s;
  assign rem_s = (div_sgn_s && a[31]) ? (32'd0 - rm_s) : rm_s;

  // Operation decode and result selection.
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    wr_en  = 1'b0;
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MD_MULT: begin
        is_mul = 1'b1;
        wr_en  = 1'b1;
        {res_hi, res_lo} = prod_s_s;
      end
      MD_MULTU: begin
        is_mul = 1'b1;
        wr_en  = 1'b1;
        {res_hi, res_lo} = prod_u_s;
      end
      MD_DIV, MD_DIVU: begin
        is_div = 1'b1;
        wr_en  = (b != 32'd0);
        res_hi = rem_s;
        res_lo = quo_s;
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        is_mul = 1'b1;
        wr_en  = 1'b1;
        {res_hi, res_lo} = {hi, lo} + prod_s_s;
      end
      MD_MADDU: begin
        is_mul = 1'b1;
        wr_en  = 1'b1;
        {res_hi, res_lo} = {hi, lo} + prod_u_s;
      end
`endif
      default: begin
        is_mul = 1'b0;
        wr_en  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// MIPS-style multiply/divide unit: HI/LO, busy counter and pending result.
// MDU_MADD_EN enables MADD/MADDU; otherwise those codes act as NONE.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] MDout
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  logic          accept_s, is_mul_s, is_div_s, wr_en_s;
  logic [31:0]   res_hi_s, res_lo_s;

  assign accept_s = start & ~Req & ~busy_q;
  assign busy     = busy_q;

  mdu_arith u_arith (
    .op     (md_op),
    .a      (A),
    .b      (B),
`ifdef MDU_MADD_EN
    .hi     (hi_q),
    .lo     (lo_q),
`endif
    .is_mul (is_mul_s),
    .is_div (is_div_s),
    .wr_en  (wr_en_s),
    .res_hi (res_hi_s),
    .res_lo (res_lo_s)
  );

  // Next-state: countdown of an in-flight op, or acceptance of a new one.
  always_comb begin
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d    = 1'b0;
        pend_wr_d = 1'b0;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end else begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      end else begin
        busy_d = 1'b1;
      end
    end else if (accept_s) begin
      if (is_mul_s || is_div_s) begin
        busy_d    = 1'b1;
        cnt_d     = is_mul_s ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        pend_hi_d = res_hi_s;
        pend_lo_d = res_lo_s;
        pend_wr_d = wr_en_s;
      end else if (md_op == MD_MTHI) begin
        hi_d = A;
      end else if (md_op == MD_MTLO) begin
        lo_d = A;
      end else begin
        busy_d = 1'b0;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // State registers; reset drops any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // HI/LO read mux.
  always_comb begin
    case (md_op)
      MD_MFHI: MDout = hi_q;
      MD_MFLO: MDout = lo_q;
      default: MDout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] MDout;

  int checks = 0;
  int errors = 0;

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .Req   (Req),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .MDout (MDout)
  );

  always #5 clk = ~clk;

  // Present one op for a single cycle starting now (caller sits just after a negedge).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic req);
    start = 1'b1; md_op = op; A = a; B = b; Req = req;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE; A = 32'd0; B = 32'd0; Req = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [3:0] op, output logic [31:0] v);
    md_op = op;
    #1;
    v = MDout;
    md_op = MD_NONE;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; Req = 1'b0; start = 1'b0; md_op = MD_NONE; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (MDout !== 32'd0) begin errors++; $display("FAIL reset_none_out: got %h expected 0", MDout); end
    reset = 1'b0;
    @(negedge clk);
    rd(MD_MFHI, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", v); end
    rd(MD_MFLO, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", v); end
  endtask

  task automatic test_mult();
    logic [31:0] v; int n;
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("FAIL mult_busy: got %0d expected 5", n); end
    rd(MD_MFHI, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", v); end
    rd(MD_MFLO, v);
    checks++; if (v !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", v); end
    @(negedge clk);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("FAIL multu_busy: got %0d expected 5", n); end
    rd(MD_MFHI, v);
    checks++; if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", v); end
    rd(MD_MFLO, v);
    checks++; if (v !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", v); end
  endtask

  task automatic test_div();
    logic [31:0] v; int n;
    @(negedge clk);
    issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL divu_busy: got %0d expected 10", n); end
    rd(MD_MFLO, v);
    checks++; if (v !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", v); end
    rd(MD_MFHI, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 00000002", v); end
    @(negedge clk);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    count_busy(n);
    rd(MD_MFLO, v);
    checks++; if (v !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", v); end
    rd(MD_MFHI, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", v); end
    @(negedge clk);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    count_busy(n);
    rd(MD_MFLO, v);
    checks++; if (v !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", v); end
    rd(MD_MFHI, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", v); end
  endtask

  task automatic test_div_zero();
    logic [31:0] v; int n;
    @(negedge clk);
    issue(MD_MTHI, 32'h11, 32'd0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
    issue(MD_MTLO, 32'h22, 32'd0, 1'b0);
    issue(MD_DIV, 32'd5, 32'd0, 1'b0);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL divz_busy: got %0d expected 10", n); end
    rd(MD_MFHI, v);
    checks++; if (v !== 32'h11) begin errors++; $display("FAIL divz_hi: got %h expected 00000011", v); end
    rd(MD_MFLO, v);
    checks++; if (v !== 32'h22) begin errors++; $display("FAIL divz_lo: got %h expected 00000022", v); end
  endtask

  task automatic test_req_block();
    logic [31:0] v;
    @(negedge clk);
    issue(MD_MULT, 32'd2, 32'd3, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_busy: got %b expected 0", busy); end
    issue(MD_MTHI, 32'h99, 32'd0, 1'b1);
    repeat (6) @(negedge clk);
    rd(MD_MFHI, v);
    checks++; if (v !== 32'h11) begin errors++; $display("FAIL req_hi: got %h expected 00000011", v); end
    rd(MD_MFLO, v);
    checks++; if (v !== 32'h22) begin errors++; $display("FAIL req_lo: got %h expected 00000022", v); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] v; int n;
    @(negedge clk);
    issue(MD_MULT, 32'd6, 32'd7, 1'b0);
    issue(MD_MTHI, 32'd5, 32'd0, 1'b0);
    count_busy(n);
    checks++; if (n != 4) begin errors++; $display("FAIL busy_ign_remaining: got %0d expected 4", n); end
    rd(MD_MFHI, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL busy_ign_hi: got %h expected 00000000", v); end
    rd(MD_MFLO, v);
    checks++; if (v !== 32'd42) begin errors++; $display("FAIL busy_ign_lo: got %h expected 0000002a", v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v; int n;
    @(negedge clk);
    issue(MD_MULTU, 32'd2, 32'd3, 1'b0);
    count_busy(n);
    issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", busy); end
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL b2b_busy: got %0d expected 10", n); end
    rd(MD_MFLO, v);
    checks++; if (v !== 32'd14) begin errors++; $display("FAIL b2b_lo: got %h expected 0000000e", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    @(negedge clk);
    issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_late: got %b expected 0", busy); end
    rd(MD_MFHI, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rstmid_hi: got %h expected 00000000", v); end
    rd(MD_MFLO, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rstmid_lo: got %h expected 00000000", v); end
  endtask

  task automatic test_madd();
    logic [31:0] v; int n;
    @(negedge clk);
    issue(MD_MTHI, 32'd0, 32'd0, 1'b0);
    issue(MD_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(MD_MADDU, 32'd1, 32'd1, 1'b0);
    count_busy(n);
    rd(MD_MFHI, v);
`ifdef MDU_MADD_EN
    checks++; if (n != 5) begin errors++; $display("FAIL maddu_busy: got %0d expected 5", n); end
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL maddu_hi: got %h expected 00000001", v); end
    rd(MD_MFLO, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL maddu_lo: got %h expected 00000000", v); end
    @(negedge clk);
    issue(MD_MADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
    count_busy(n);
    rd(MD_MFHI, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL madd_hi: got %h expected 00000000", v); end
    rd(MD_MFLO, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL madd_lo: got %h expected ffffffff", v); end
`else
    checks++; if (n != 0) begin errors++; $display("FAIL maddu_off_busy: got %0d expected 0", n); end
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL maddu_off_hi: got %h expected 00000000", v); end
    rd(MD_MFLO, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL maddu_off_lo: got %h expected ffffffff", v); end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_req_block();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_madd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, busy length of MULT/MULTU (and MADD/MADDU).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, busy length of DIV/DIVU.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 Req  input  1  exception/interrupt flush; the E-stage instruction this cycle is cancelled.
REQ-007 start  input  1  E-stage MDU instruction valid this cycle.
REQ-008 md_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, others NONE.
REQ-009 A  input  32  rs operand (forwarded).
REQ-010 B  input  32  rt operand (forwarded).
REQ-011 busy  output  1  registered; high while an arithmetic op is in flight.
REQ-012 MDout  output  32  HI for MFHI, LO for MFLO, else 0; combinational from current HI/LO.

Function
REQ-013 The block SHALL accept an op only when start=1, Req=0 and busy=0; otherwise the op is ignored (hazard unit stalls on start|busy).
REQ-014 An accepted MULT/MULTU/MADD/MADDU SHALL latch operands and result at that edge, load counter with MULT_CYCLES, and hold busy high for exactly MULT_CYCLES cycles after that edge.
REQ-015 An accepted DIV/DIVU SHALL likewise hold busy for exactly DIV_CYCLES cycles.
REQ-016 HI/LO SHALL update at the edge where counter goes 1->0; busy falls at the same edge, so MFHI/MFLO in the next cycle read the new value.
REQ-017 MULT: {HI,LO} = signed 64-bit A*B; MULTU: unsigned.
REQ-018 DIV: LO = signed A/B truncated toward zero, HI = remainder with sign of A; DIVU: unsigned.
REQ-019 Divide by zero SHALL leave HI/LO unchanged while still asserting busy for DIV_CYCLES.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-021 Accepted MTHI/MTLO SHALL write A into HI/LO at that edge with no busy.
REQ-022 Req SHALL NOT abort an op already in flight; it only blocks acceptance in its own cycle.
REQ-023 MFHI/MFLO SHALL have no side effect on state.

Reset
REQ-024 On reset: HI=0, LO=0, counter=0, busy=0, pending result discarded; MDout=0 unless MFHI/MFLO selects a zero register.
REQ-025 Reset asserted mid-operation SHALL cancel it; no HI/LO write occurs.

Configuration
REQ-026 With MDU_MADD_EN defined, MADD/MADDU SHALL compute {HI,LO} += A*B (signed/unsigned, 64-bit wrap) with MULT_CYCLES latency.
REQ-027 Without MDU_MADD_EN, op codes 9 and 10 SHALL behave as NONE (no busy, no state change).

Structure
REQ-028 Op encodings and default latency constants SHALL live in shared package mdu_pkg.
REQ-029 Combinational arithmetic (mul/div/accumulate, corner cases) SHALL be in sub-module mdu_arith; mdu holds counter, busy, HI/LO and pending registers.

Verification
REQ-030 MULT A=0xFFFFFFFE B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 DIVU A=100 B=7 -> busy high 10 cycles, then LO=14, HI=2; DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 DIV B=0 with HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO remain 0x11/0x22.
REQ-033 MULT start with Req=1 -> busy stays 0, HI/LO unchanged; MTHI A=5 with busy=1 -> ignored.
REQ-034 Reset pulse in cycle 3 of DIV -> busy=0 immediately, HI=LO=0, no later write.
REQ-035 MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1 B=1 -> HI=1, LO=0; without macro -> no change, busy 0.
